// File: rtl/alu4_acc_ctrl.sv
// Accumulator controller for the alu4 slice: a command FIFO feeding an IDLE/EXEC/DONE sequencer.
// Optional sticky-overflow output enabled by defining ALU4_ACC_STICKY_V_EN.
`timescale 1ns/1ps
module alu4_acc_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    output logic [WIDTH-1:0] acc,
    output logic [3:0]       flags,
    output logic             done,
`ifdef ALU4_ACC_STICKY_V_EN
    output logic             v_sticky,
`endif
    output logic             busy
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 1 + 3 + WIDTH;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state;
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fifo_nempty;
    logic               push;
    logic               pop;
    logic               load_p0;

    function automatic logic [3:0] load_flags(input logic [WIDTH-1:0] d);
        return {1'b0, d[WIDTH-1], (d == '0), 1'b0};
    endfunction

    assign fifo_nempty = (count != '0);
    assign cmd_ready   = (count != CNT_W'(DEPTH));
    assign push        = cmd_valid && cmd_ready;
    assign pop         = ((state == IDLE) || (state == DONE)) && fifo_nempty;
    assign head        = fifo_mem[rd_ptr];
    assign alu_a       = acc;
    assign busy        = (state != IDLE) || fifo_nempty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_load, cmd_op, cmd_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // alu_b/alu_op are the registered command; they hold outside EXEC so the ALU sees stable inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            load_p0  <= 1'b0;
            alu_b    <= '0;
            alu_op   <= 3'b000;
            acc      <= '0;
            flags    <= 4'b0000;
            done     <= 1'b0;
`ifdef ALU4_ACC_STICKY_V_EN
            v_sticky <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_nempty) begin
                        {load_p0, alu_op, alu_b} <= head;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (load_p0) begin
                        acc   <= alu_b;
                        flags <= load_flags(alu_b);
`ifdef ALU4_ACC_STICKY_V_EN
                        v_sticky <= 1'b0;
`endif
                    end else begin
                        acc   <= alu_result;
                        flags <= {alu_c, alu_n, alu_z, alu_v};
`ifdef ALU4_ACC_STICKY_V_EN
                        if (alu_v) v_sticky <= 1'b1;
`endif
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (fifo_nempty) begin
                        {load_p0, alu_op, alu_b} <= head;
                        state <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_acc_ctrl.sv
// Directed bench for alu4_acc_ctrl with a behavioural alu4 attached to the ALU ports.
`timescale 1ns/1ps
module tb_alu4_acc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_c, alu_n, alu_z, alu_v;
    logic [3:0] acc;
    logic [3:0] flags;
    logic       done;
    logic       busy;
`ifdef ALU4_ACC_STICKY_V_EN
    logic       v_sticky;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [3:0] done_acc[$];
    int         done_cyc[$];

    alu4_acc_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .acc(acc), .flags(flags), .done(done),
`ifdef ALU4_ACC_STICKY_V_EN
        .v_sticky(v_sticky),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural alu4: 000 NOT A, 001 AND, 010 OR, 011 XOR, 100 A, 101 B, 110 ADD, 111 SUB
    always_comb begin
        logic [4:0] sum;
        sum        = 5'd0;
        alu_result = 4'd0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (alu_op)
            3'b000: alu_result = ~alu_a;
            3'b001: alu_result = alu_a & alu_b;
            3'b010: alu_result = alu_a | alu_b;
            3'b011: alu_result = alu_a ^ alu_b;
            3'b100: alu_result = alu_a;
            3'b101: alu_result = alu_b;
            3'b110: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum[3:0];
                alu_c      = sum[4];
                alu_v      = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
            end
            default: begin
                sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_result = sum[3:0];
                alu_c      = sum[4];
                alu_v      = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
            end
        endcase
        alu_n = alu_result[3];
        alu_z = (alu_result == 4'd0);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_acc.push_back(acc);
            done_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_cmd(input logic l, input logic [2:0] op, input logic [3:0] d);
        int t;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) check("push_ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_load  = l;
        cmd_op    = op;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check(tag, done_cnt, target);
    endtask

    task automatic run_pair(input string tag, input logic [3:0] ld, input logic [2:0] op,
                            input logic [3:0] d, input logic [3:0] exp_acc, input logic [3:0] exp_flags);
        int base;
        base = done_cnt;
        push_cmd(1'b1, 3'b000, ld);
        push_cmd(1'b0, op, d);
        wait_done({tag, "_done"}, base + 2);
        check({tag, "_acc"}, acc, exp_acc);
        check({tag, "_flags"}, flags, exp_flags);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base, pc, i, t, nb;
        logic pushing, saw_full;

        reset = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'b000; cmd_data = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_acc", acc, 4'h0);
        check("rst_flags", flags, 4'h0);
        check("rst_alu_b", alu_b, 4'h0);
        check("rst_alu_op", alu_op, 3'b000);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
`ifdef ALU4_ACC_STICKY_V_EN
        check("rst_vsticky", v_sticky, 1'b0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Load 0xA then ADD 0x3, with latency and done-count checks
        base = done_cnt;
        push_cmd(1'b1, 3'b000, 4'hA);
        pc = cyc;
        push_cmd(1'b0, 3'b110, 4'h3);
        wait_done("t1_done", base + 2);
        check("t1_acc", acc, 4'hD);
        check("t1_flags", flags, 4'b0100);
        check("t1_latency", done_cyc[base] - pc, 2);
        check("t1_load_acc", done_acc[base], 4'hA);
        repeat (6) @(negedge clk);
        check("t1_two_done", done_cnt - base, 2);
        check("t1_idle_busy", busy, 1'b0);

        run_pair("t2_sub_neg", 4'h5, 3'b111, 4'h7, 4'hE, 4'b0100);
        run_pair("t2_sub_zero", 4'hA, 3'b111, 4'hA, 4'h0, 4'b1010);

        // Load of zero sets z only
        base = done_cnt;
        push_cmd(1'b1, 3'b000, 4'h0);
        wait_done("t2_ld0_done", base + 1);
        check("t2_ld0_flags", flags, 4'b0010);

        // Signed overflow, then AND, then load
        run_pair("t3_ovf", 4'h7, 3'b110, 4'h7, 4'hE, 4'b0101);
`ifdef ALU4_ACC_STICKY_V_EN
        check("t3_vsticky_set", v_sticky, 1'b1);
`endif
        base = done_cnt;
        push_cmd(1'b0, 3'b001, 4'hF);
        wait_done("t3_and_done", base + 1);
        check("t3_and_acc", acc, 4'hE);
        check("t3_and_flags", flags, 4'b0100);
`ifdef ALU4_ACC_STICKY_V_EN
        check("t3_vsticky_hold", v_sticky, 1'b1);
`endif
        base = done_cnt;
        push_cmd(1'b1, 3'b000, 4'h3);
        wait_done("t3_ld_done", base + 1);
        check("t3_ld_flags", flags, 4'b0000);
`ifdef ALU4_ACC_STICKY_V_EN
        check("t3_vsticky_clr", v_sticky, 1'b0);
`endif

        // Burst with cmd_valid held: load 1 then seven ADD 1
        base = done_cnt;
        i = 0; t = 0; saw_full = 1'b0;
        cmd_load = 1'b1; cmd_op = 3'b000; cmd_data = 4'h1; cmd_valid = 1'b1;
        while (i < 8 && t < 200) begin
            pushing = cmd_ready;
            if (!cmd_ready) saw_full = 1'b1;
            @(negedge clk);
            t++;
            if (pushing) begin
                i++;
                cmd_load = 1'b0; cmd_op = 3'b110; cmd_data = 4'h1;
            end
        end
        cmd_valid = 1'b0;
        check("t4_pushed", i, 8);
        check("t4_saw_full", saw_full, 1'b1);
        wait_done("t4_done", base + 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("t4_acc%0d", k), done_acc[base + k], k + 1);
        for (int k = 1; k < 8; k++)
            check($sformatf("t4_gap%0d", k), done_cyc[base + k] - done_cyc[base + k - 1], 2);

        // Reset during EXEC of an ADD
        push_cmd(1'b1, 3'b000, 4'h5);
        push_cmd(1'b0, 3'b110, 4'h3);
        t = 0;
        while (alu_op != 3'b110 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t5_in_exec_op", alu_op, 3'b110);
        check("t5_in_exec_acc", acc, 4'h5);
        nb = done_cnt;
        reset = 1'b1;
        #1;
        check("t5_rst_acc", acc, 4'h0);
        check("t5_rst_flags", flags, 4'h0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_done", done, 1'b0);
        check("t5_rst_op", alu_op, 3'b000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_no_done", done_cnt, nb);
        check("t5_ready", cmd_ready, 1'b1);
        run_pair("t5_after", 4'h2, 3'b110, 4'h2, 4'h4, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
